// File: rtl/data_memory_pkg.sv
// ============================================================================
// Module      : data_memory_pkg
// Description : Shared types and helpers for the wait-stated data memory.
//               Access FSM state encoding, wait-state counter sizing and
//               the big-endian byte-lane mapping helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_memory_pkg;

    // Largest supported WAIT_STATES value; sizes the wait-state counter.
    localparam int MAX_WAIT_STATES = 15;
    localparam int CNT_WIDTH       = $clog2(MAX_WAIT_STATES + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Big-endian lane mapping: the byte at word offset 0 occupies the most
    // significant lane. Returns the LSB index of that byte's 8-bit slice.
    function automatic int lane_of(input int offset, input int nb);
        return (nb - 1 - offset) * 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_byte_array.sv
// ============================================================================
// Module      : dmem_byte_array
// Description : NB-lane byte storage. One byte-wide array per lane, clocked
//               write with per-lane enable, combinational full-word read.
//               Contents start at zero and are never cleared by reset.
// Ports       : clk       - rising-edge clock
//               i_wr_en   - write strobe (already qualified by caller)
//               i_addr    - word address
//               i_lane_en - lane enables, bit NB-1 = byte at word offset 0
//               i_wdata   - big-endian write word
//               o_rdata   - big-endian read word at i_addr
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_byte_array
    import data_memory_pkg::*;
#(
    parameter int WORD_AW = 10,
    parameter int NB      = 4
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [WORD_AW-1:0]  i_addr,
    input  logic [NB-1:0]       i_lane_en,
    input  logic [NB*8-1:0]     i_wdata,
    output logic [NB*8-1:0]     o_rdata
);

    localparam int C_DEPTH = 2 ** WORD_AW;

    for (genvar k = 0; k < NB; k++) begin : g_lane
        localparam int C_LSB = lane_of(k, NB);

        logic [7:0] r_mem [C_DEPTH] = '{default: '0};

        always_ff @(posedge clk) begin
            if (i_wr_en && i_lane_en[NB-1-k]) begin
                r_mem[i_addr] <= i_wdata[C_LSB +: 8];
            end
        end

        assign o_rdata[C_LSB +: 8] = r_mem[i_addr];
    end

endmodule

`default_nettype wire

// File: rtl/data_memory_ws.sv
// ============================================================================
// Module      : data_memory_ws
// Description : Byte-addressable big-endian data memory with byte enables,
//               misalignment rejection and WAIT_STATES extra cycles per
//               access. Holds the access FSM, request latch and output
//               registers; storage lives in dmem_byte_array.
// Ports       : clk, reset (async, active low), clock_enable (freezes all)
//               address/write_data/byte_enable/write/read - request
//               waitrequest - high while an accepted access is in flight
//               read_data/read_valid - registered read word + 1-cycle strobe
//               misaligned  - 1-cycle strobe for a rejected request
// Config      : DMEM_BOUNDS_CHECK_EN - reject addresses >= 2**ADDR_WIDTH
//               instead of wrapping them modulo the depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_ws
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clock_enable,
    input  logic [31:0]             address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    input  logic                    write,
    input  logic                    read,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    misaligned
);

    localparam int C_NB      = DATA_WIDTH / 8;
    localparam int C_OFF_W   = (C_NB > 1) ? $clog2(C_NB) : 0;
    localparam int C_WORD_AW = ADDR_WIDTH - C_OFF_W;

    localparam logic [CNT_WIDTH-1:0] C_WS      = CNT_WIDTH'(WAIT_STATES);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [0:0]           C_ST_IDLE = 1'(IDLE);
    localparam logic [0:0]           C_ST_BUSY = 1'(BUSY);

    logic [0:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                  w_misalign;
    logic                  w_out_of_range;
    logic                  w_reject;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_do_access;
    logic                  w_acc_write;
    logic [C_WORD_AW-1:0]  w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_wdata;
    logic [C_NB-1:0]       w_acc_be;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    if (C_NB > 1) begin : g_align
        assign w_misalign = |address[C_OFF_W-1:0];
    end else begin : g_no_align
        assign w_misalign = 1'b0;
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_out_of_range = |address[31:ADDR_WIDTH];
`else
    // Upper address bits are don't-care: accesses wrap modulo the depth.
    logic w_unused_hi;
    assign w_unused_hi    = ^address[31:ADDR_WIDTH];
    assign w_out_of_range = 1'b0;
`endif

    assign w_reject = w_misalign | w_out_of_range;
    // Requests are only looked at while idle; a master held off by
    // waitrequest is simply not seen until the FSM returns to IDLE.
    assign w_accept = clock_enable & (r_state == C_ST_IDLE) & (read | write);
    assign w_start  = w_accept & ~w_reject;

    // ------------------------------------------------------------------
    // Access source: live request for zero wait states, latched otherwise
    // ------------------------------------------------------------------
    if (WAIT_STATES == 0) begin : g_ws_zero
        assign w_do_access = w_start;
        assign w_acc_write = write;
        assign w_acc_addr  = address[ADDR_WIDTH-1:C_OFF_W];
        assign w_acc_wdata = write_data;
        assign w_acc_be    = byte_enable;
    end else begin : g_ws_latched
        logic                  r_req_write;
        logic [C_WORD_AW-1:0]  r_req_addr;
        logic [DATA_WIDTH-1:0] r_req_wdata;
        logic [C_NB-1:0]       r_req_be;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_req_write <= 1'b0;
                r_req_addr  <= '0;
                r_req_wdata <= '0;
                r_req_be    <= '0;
            end else if (w_start) begin
                // Write takes priority when both strobes are raised.
                r_req_write <= write;
                r_req_addr  <= address[ADDR_WIDTH-1:C_OFF_W];
                r_req_wdata <= write_data;
                r_req_be    <= byte_enable;
            end
        end

        assign w_do_access = clock_enable & (r_state == C_ST_BUSY) & (r_cnt == C_CNT_ONE);
        assign w_acc_write = r_req_write;
        assign w_acc_addr  = r_req_addr;
        assign w_acc_wdata = r_req_wdata;
        assign w_acc_be    = r_req_be;
    end

    // ------------------------------------------------------------------
    // Access FSM: IDLE -> BUSY for WAIT_STATES cycles, access on cnt==1
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= C_ST_IDLE;
            r_cnt   <= '0;
        end else if (clock_enable) begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_start && (WAIT_STATES > 0)) begin
                        r_state <= C_ST_BUSY;
                        r_cnt   <= C_WS;
                    end
                end
                C_ST_BUSY: begin
                    if (r_cnt == C_CNT_ONE) begin
                        r_state <= C_ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign waitrequest = (r_state == C_ST_BUSY);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    dmem_byte_array #(
        .WORD_AW (C_WORD_AW),
        .NB      (C_NB)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (w_do_access & w_acc_write),
        .i_addr    (w_acc_addr),
        .i_lane_en (w_acc_be),
        .i_wdata   (w_acc_wdata),
        .o_rdata   (w_rd_word)
    );

    // ------------------------------------------------------------------
    // Output registers; read_data keeps the last completed read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            misaligned <= 1'b0;
        end else if (clock_enable) begin
            read_valid <= w_do_access & ~w_acc_write;
            misaligned <= w_accept & w_reject;
            if (w_do_access && !w_acc_write) begin
                read_data <= w_rd_word;
            end
        end
    end

endmodule

`default_nettype wire
